// File: rtl/led_scan_ctrl.sv
// Multiplexed scan controller for the six-digit clock display.
// Shadow digits are updated only at frame boundaries or while scanning is parked.
module led_scan_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int DWELL      = 1000,
  parameter int BLANK      = 4
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Enable,
  input  logic                    LZBlank,
  input  logic [NUM_DIGITS-1:0]   DpMask,
  input  logic [4*NUM_DIGITS-1:0] TimeData,
  input  logic                    LoadReq,
  output logic                    LoadAck,
  output logic [7:0]              ScanBin,
  input  logic [7:0]              SegIn,
  output logic [7:0]              SegOut,
  output logic [NUM_DIGITS-1:0]   DigitSel
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(DWELL);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] LAST_CNT   = CW'(DWELL - 1);
  localparam logic [CW-1:0] LAST_BLANK = CW'(BLANK - 1);

  typedef enum logic {S_BLANK, S_SHOW} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [7:0]              scan_d, seg_d;
  logic [NUM_DIGITS-1:0]   sel_d;
  logic                    ack_d;
  logic                    slot_end, frame_end;
  logic [3:0]              nibble;
  logic                    dp;
  logic                    unused_seg7;

  assign unused_seg7 = SegIn[7];
  assign slot_end    = (cnt_q == LAST_CNT);
  assign frame_end   = slot_end && (idx_q == LAST_IDX);

  always_comb begin
    state_d  = S_BLANK;
    idx_d    = '0;
    cnt_d    = '0;
    shadow_d = shadow_q;
    scan_d   = 8'hFF;
    seg_d    = '0;
    sel_d    = '0;
    ack_d    = 1'b0;
    nibble   = '0;
    dp       = 1'b0;

    // The ack cycle itself never accepts, so a held request waits for the next opportunity
    if (LoadReq && !LoadAck && (frame_end || !Enable)) begin
      shadow_d = TimeData;
      ack_d    = 1'b1;
    end

    if (Enable) begin
      cnt_d = slot_end ? '0 : cnt_q + 1'b1;
      if (!slot_end)
        idx_d = idx_q;
      else if (idx_q == LAST_IDX)
        idx_d = '0;
      else
        idx_d = idx_q + 1'b1;

      case (state_q)
        S_BLANK: state_d = (cnt_q == LAST_BLANK) ? S_SHOW : S_BLANK;
        S_SHOW:  state_d = slot_end ? S_BLANK : S_SHOW;
        default: state_d = S_BLANK;
      endcase

      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_d == IW'(i)) begin
          nibble = shadow_d[4*i +: 4];
          if (state_d == S_SHOW)
            sel_d[i] = 1'b1;
        end
        if (idx_q == IW'(i))
          dp = DpMask[i];
      end

      scan_d = (LZBlank && (idx_d == LAST_IDX) && (nibble == 4'h0)) ? 8'hFF : {4'h0, nibble};
      seg_d  = {dp, SegIn[6:0]};
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= S_BLANK;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      ScanBin  <= 8'hFF;
      SegOut   <= '0;
      DigitSel <= '0;
      LoadAck  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      ScanBin  <= scan_d;
      SegOut   <= seg_d;
      DigitSel <= sel_d;
      LoadAck  <= ack_d;
    end
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Bench for led_scan_ctrl: table vectors, directed handshake/enable/reset sequences,
// and random traffic checked against a time-position model of the scan.
module tb_led_scan_ctrl;

  localparam int N     = 6;
  localparam int DW    = 8;
  localparam int BL    = 2;
  localparam int FRAME = N * DW;

  logic           Clk = 1'b0;
  logic           Rst, Enable, LZBlank, LoadReq, LoadAck;
  logic [N-1:0]   DpMask, DigitSel;
  logic [4*N-1:0] TimeData;
  logic [7:0]     ScanBin, SegIn, SegOut;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ackCount = 0;
  bit chkEn = 1'b0;

  int             mT, mPreIdx;
  logic [4*N-1:0] mShadow;
  logic           mAck, mAccept;
  logic [7:0]     mScan, mSeg, mPreScan, mTmp;
  logic [N-1:0]   mSel;

  typedef struct {
    int         cycle;
    logic [5:0] sel;
    logic [7:0] scan;
  } vec_t;
  vec_t vecs[11];

  led_scan_ctrl #(.NUM_DIGITS(N), .DWELL(DW), .BLANK(BL)) dut (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .LZBlank(LZBlank), .DpMask(DpMask),
    .TimeData(TimeData), .LoadReq(LoadReq), .LoadAck(LoadAck), .ScanBin(ScanBin),
    .SegIn(SegIn), .SegOut(SegOut), .DigitSel(DigitSel)
  );

  always #5 Clk = ~Clk;

  // BinToLED stand-in; bit 7 is deliberately set so the DUT must ignore it
  function automatic logic [7:0] segOf(input logic [7:0] b);
    logic [6:0] s;
    case (b)
      8'd0: s = 7'h3F; 8'd1: s = 7'h06; 8'd2: s = 7'h5B; 8'd3: s = 7'h4F; 8'd4: s = 7'h66;
      8'd5: s = 7'h6D; 8'd6: s = 7'h7D; 8'd7: s = 7'h07; 8'd8: s = 7'h7F; 8'd9: s = 7'h6F;
      default: s = 7'h00;
    endcase
    return {1'b1, s};
  endfunction

  assign SegIn = segOf(ScanBin);

  function automatic logic [7:0] digitVal(input int d, input logic [4*N-1:0] sh, input logic lz);
    int nib;
    nib = int'((sh >> (4 * d)) & 24'hF);
    if (lz && d == N - 1 && nib == 0) return 8'hFF;
    return 8'(nib);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic lz, input logic [N-1:0] dp,
                               input logic [4*N-1:0] td, input logic req);
    Enable = en; LZBlank = lz; DpMask = dp; TimeData = td; LoadReq = req;
  endtask

  task automatic tick();
    @(negedge Clk);
    cyc++;
    if (LoadAck === 1'b1) ackCount++;
  endtask

  task automatic gotoCycle(input int target);
    while (cyc < target) tick();
  endtask

  task automatic waitAck(input int budget);
    int n = 0;
    while (LoadAck !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checkOutput("ack_seen", LoadAck, 1);
  endtask

  // Model: position in the frame is just elapsed enabled cycles modulo the frame length
  always @(posedge Clk) begin
    if (Rst) begin
      mT = 0; mShadow = '0; mAck = 1'b0; mScan = 8'hFF; mSeg = '0; mSel = '0;
    end else begin
      mPreIdx  = (mT / DW) % N;
      mPreScan = mScan;
      mAccept  = LoadReq && !mAck && (!Enable || (mT % FRAME) == FRAME - 1);
      mAck     = mAccept;
      if (mAccept) mShadow = TimeData;
      if (!Enable) begin
        mT = 0; mScan = 8'hFF; mSeg = '0; mSel = '0;
      end else begin
        mT   = (mT + 1) % FRAME;
        mTmp = segOf(mPreScan);
        mSeg = {DpMask[mPreIdx], mTmp[6:0]};
        mScan = digitVal((mT / DW) % N, mShadow, LZBlank);
        mSel = ((mT % DW) >= BL) ? (N'(1) << ((mT / DW) % N)) : '0;
      end
    end
    #1;
    if (chkEn) begin
      checkOutput("model_sel", DigitSel, mSel);
      checkOutput("model_scan", ScanBin, mScan);
      checkOutput("model_seg", SegOut, mSeg);
      checkOutput("model_ack", LoadAck, mAck);
    end
  end

  initial begin
    int a0;
    vecs[0]  = '{0,  6'h00, 8'hFF};
    vecs[1]  = '{1,  6'h00, 8'h00};
    vecs[2]  = '{2,  6'h01, 8'h00};
    vecs[3]  = '{7,  6'h01, 8'h00};
    vecs[4]  = '{8,  6'h00, 8'h00};
    vecs[5]  = '{9,  6'h00, 8'h00};
    vecs[6]  = '{10, 6'h02, 8'h00};
    vecs[7]  = '{26, 6'h08, 8'h00};
    vecs[8]  = '{47, 6'h20, 8'h00};
    vecs[9]  = '{48, 6'h00, 8'h00};
    vecs[10] = '{50, 6'h01, 8'h00};

    Rst = 1'b1;
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    chkEn = 1'b1;
    cyc = 0;
    checkOutput("rst_ack", LoadAck, 0);
    checkOutput("rst_seg", SegOut, 0);

    for (int i = 0; i < 11; i++) begin
      gotoCycle(vecs[i].cycle);
      checkOutput($sformatf("vec%0d_sel", i), DigitSel, vecs[i].sel);
      checkOutput($sformatf("vec%0d_scan", i), ScanBin, vecs[i].scan);
    end

    // Mid-frame load is held until the frame end at cycle 95->96
    a0 = ackCount;
    applyStimulus(1'b1, 1'b0, '0, 24'h123456, 1'b1);
    waitAck(100);
    checkOutput("load_ack_cycle", cyc, 96);
    checkOutput("load_first_scan", ScanBin, 8'h06);
    LoadReq = 1'b0;
    for (int d = 0; d < N; d++) begin
      gotoCycle(96 + 8 * d + 3);
      checkOutput($sformatf("load_digit%0d", d), ScanBin, 32'(6 - d));
      if (d == 0) checkOutput("load_seg0", SegOut, 8'b01111101);
    end
    checkOutput("load_ack_once", ackCount - a0, 1);

    applyStimulus(1'b1, 1'b1, '0, 24'h012345, 1'b1);
    waitAck(100);
    checkOutput("lz_ack_cycle", cyc, 144);
    LoadReq = 1'b0;
    gotoCycle(144 + 35);
    checkOutput("lz_digit4_scan", ScanBin, 8'h01);
    gotoCycle(144 + 43);
    checkOutput("lz_digit5_scan", ScanBin, 8'hFF);
    checkOutput("lz_digit5_seg", SegOut, 8'h00);
    LZBlank = 1'b0;
    gotoCycle(192 + 43);
    checkOutput("nolz_digit5_scan", ScanBin, 8'h00);
    checkOutput("nolz_digit5_seg", SegOut, 8'b00111111);

    DpMask = 6'b010100;
    for (int d = 0; d < N; d++) begin
      gotoCycle(240 + 8 * d + 4);
      checkOutput($sformatf("dp_digit%0d", d), SegOut[7], (d == 2 || d == 4) ? 1 : 0);
      checkOutput($sformatf("dp_sel%0d", d), DigitSel, 32'(1 << d));
    end
    DpMask = '0;

    gotoCycle(290);
    applyStimulus(1'b0, 1'b0, '0, 24'h654321, 1'b1);
    tick();
    checkOutput("dis_sel", DigitSel, 0);
    checkOutput("dis_seg", SegOut, 0);
    checkOutput("dis_scan", ScanBin, 8'hFF);
    checkOutput("dis_ack", LoadAck, 1);
    LoadReq = 1'b0;
    tick();
    checkOutput("dis_ack_drop", LoadAck, 0);
    Enable = 1'b1;
    cyc = 0;
    tick();
    checkOutput("reen_blank", DigitSel, 0);
    tick();
    checkOutput("reen_sel", DigitSel, 6'b000001);
    checkOutput("reen_scan", ScanBin, 8'h01);

    gotoCycle(20);
    applyStimulus(1'b1, 1'b0, '0, 24'h999999, 1'b1);
    tick(); tick(); tick();
    a0 = ackCount;
    Rst = 1'b1;
    LoadReq = 1'b0;
    tick();
    checkOutput("rst_mid_sel", DigitSel, 0);
    checkOutput("rst_mid_seg", SegOut, 0);
    checkOutput("rst_mid_scan", ScanBin, 8'hFF);
    checkOutput("rst_mid_ack", LoadAck, 0);
    tick();
    Rst = 1'b0;
    cyc = 0;
    gotoCycle(3);
    checkOutput("rst_shadow_scan", ScanBin, 8'h00);
    gotoCycle(60);
    checkOutput("rst_no_ack", ackCount - a0, 0);

    for (int i = 0; i < 3000; i++) begin
      tick();
      Rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 99) < 3) Enable = ~Enable;
      if ($urandom_range(0, 29) == 0) LZBlank = ~LZBlank;
      if ($urandom_range(0, 99) == 0) DpMask = N'($urandom);
      if (LoadReq && LoadAck === 1'b1) begin
        LoadReq = ($urandom_range(0, 9) == 0);
      end else if (!LoadReq && $urandom_range(0, 39) == 0) begin
        LoadReq = 1'b1;
        for (int d = 0; d < N; d++) TimeData[4*d +: 4] = 4'($urandom_range(0, 11));
      end
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_scan_ctrl.md
# led_scan_ctrl

Time-multiplexed scan controller for the digital clock's common-cathode 7-segment display bank. It holds a double-buffered copy of the six BCD time digits (HH:MM:SS) and cycles through them. For each digit it drives the binary value to the BinToLED decoder, registers the returned segment pattern with the per-digit decimal point, and asserts one digit-select line after an anti-ghosting blank interval. New time values enter through a request/acknowledge handshake and are committed only at frame boundaries, so a frame never mixes old and new digits.

## Interface
Parameters:
- NUM_DIGITS, 6, number of scanned digits; digit 0 is rightmost (seconds units).
- DWELL, 1000, clock cycles per digit slot (must be > BLANK).
- BLANK, 4, cycles at the start of each slot with all digit selects off (must be >= 2).

Ports (one clock; reset is synchronous and active-high):
- Clk  input  1  system clock, all logic on rising edge.
- Rst  input  1  synchronous active-high reset.
- Enable  input  1  scan enable; low forces the display dark and parks the scan.
- LZBlank  input  1  leading-zero suppression for digit NUM_DIGITS-1.
- DpMask  input  NUM_DIGITS  decimal point per digit, bit i applies to digit i.
- TimeData  input  4*NUM_DIGITS  BCD digits; nibble i (bits 4i+3:4i) maps to digit i.
- LoadReq  input  1  upstream requests commit of TimeData; held high until LoadAck.
- LoadAck  output  1  one-cycle pulse: TimeData was captured on the previous edge.
- ScanBin  output  8  registered binary digit value to the decoder's BinData input.
- SegIn  input  8  decoder LEDData output (combinational from ScanBin).
- SegOut  output  8  registered segment drive; bits 6:0 from SegIn, bit 7 = DP.
- DigitSel  output  NUM_DIGITS  one-hot active-high digit enable, all zero when blank.

## Operation
- Reset values: DigitSel=0, SegOut=0, ScanBin=8'hFF (decodes to blank), LoadAck=0, shadow digits=0, slot index=0, DwellCnt=0, state BLANK.
- DwellCnt counts 0..DWELL-1 in each slot. State is BLANK for DwellCnt < BLANK and SHOW otherwise.
- In BLANK, DigitSel=0. In SHOW, DigitSel has only bit idx set.
- Slot advance occurs at DwellCnt==DWELL-1:
  - idx increments and wraps from NUM_DIGITS-1 to 0.
  - DwellCnt returns to 0.
  - On the same edge, ScanBin is loaded with the new idx's value.
- Digit value rules:
  - ScanBin = {4'h0, nibble}.
  - If LZBlank=1, idx==NUM_DIGITS-1, and nibble==0, ScanBin=8'hFF.
  - Nibbles 10..15 pass through unchanged; the decoder blanks them.
- SegOut <= {DpMask[idx], SegIn[6:0]} every cycle while Enable=1. SegIn's bit 7 is ignored.
- Frame end is idx==NUM_DIGITS-1 and DwellCnt==DWELL-1:
  - If LoadReq=1 on that edge, the shadow register takes TimeData and LoadAck=1 in the next cycle.
  - ScanBin for digit 0 of the new frame is taken from TimeData, not the old shadow.
- LoadReq outside a frame end waits; it is held and not lost.
- LoadReq high after LoadAck without deassertion is a new request and is accepted at the next frame end. LoadAck never pulses on consecutive cycles.
- Enable=0:
  - On the next edge: DigitSel=0, SegOut=0, ScanBin=8'hFF, idx=0, DwellCnt=0.
  - LoadReq is accepted on any edge, with LoadAck in the next cycle.
- Enable rising: scanning restarts at digit 0, BLANK state, DwellCnt=0.
- Rst mid-slot or mid-handshake returns all state to the reset values, with no LoadAck pending.

## Timing
- Frame period is NUM_DIGITS*DWELL cycles. Each digit is lit for DWELL-BLANK cycles per frame.
- Path from slot edge to lit digit:
  - ScanBin is valid 1 cycle after the slot edge.
  - SegOut is valid 2 cycles after it.
  - DigitSel asserts BLANK cycles after it.
  - BLANK>=2 guarantees SegOut is stable before DigitSel asserts.
- DigitSel drops on the same edge as the slot advance, so there is never overlap between digits.
- LoadReq-to-LoadAck latency is 1 to NUM_DIGITS*DWELL cycles with Enable=1, and 1 cycle with Enable=0.

## Test plan
- Reset then Enable=1, DWELL=8, BLANK=2, shadow=0:
  - DigitSel is 0 for cycles 0-1, then 6'b000001 for 6 cycles, then 6'b000010.
  - The pattern wraps after 48 cycles.
- Apply TimeData=24'h123456 with LoadReq mid-frame:
  - LoadAck pulses exactly once, 1 cycle after the frame-end edge.
  - The next frame shows ScanBin 6,5,4,3,2,1 for digits 0..5.
  - SegOut for digit 0 is 8'b01111101.
- LZBlank=1, TimeData=24'h012345:
  - Digit 5 shows ScanBin=8'hFF and SegOut=0.
  - With LZBlank=0, digit 5 shows SegOut=8'b00111111.
- DpMask=6'b010100: SegOut[7]=1 only while digits 2 and 4 are selected.
- Enable=0 mid-slot:
  - Next cycle: DigitSel=0, SegOut=0.
  - A LoadReq is acknowledged 1 cycle later.
  - After re-enable, digit 0 lights BLANK cycles later.
- Rst asserted with LoadReq pending mid-frame: all outputs return to their reset values and no LoadAck appears.
